sprite_addr_scan: RTL and testbench

//  Streaming, parametrised successor to the combinational screen-to-sprite address converter.
//  - Accepts one sprite draw request: top-left screen position, orientation and colour.
//  - Rasters the SPR_W x SPR_H window and emits one (screen addr, sprite-ROM addr) pair per beat.
//  - Uses incremental counters, no divider/modulo. Clips pixels outside the screen.
//  - Sits between the game-state renderer and the frame-buffer write port.

---
 rtl/sprite_addr_scan_pkg.sv | 37 +++
 rtl/sprite_addr_scan_if.sv | 27 ++
 rtl/sprite_addr_scan_clip_chk.sv | 23 ++
 rtl/sprite_addr_scan.sv | 110 +++++++++++
 tb/tb_sprite_addr_scan.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_addr_scan_pkg.sv
// rtl/sprite_addr_scan_pkg.sv - shared geometry constants, state encoding and address helpers
package sprite_addr_scan_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPR_W    = 30;
    localparam int SPR_H    = 30;
    localparam int N_ORIENT = 4;
    localparam int N_COLOR  = 4;
    localparam int ADDR_W   = 19;
    localparam int MEM_W    = 19;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    localparam int ORI_W = $clog2(N_ORIENT);
    localparam int CLR_W = $clog2(N_COLOR);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only constant multiplies: the scan itself is purely incremental.
    function automatic logic [MEM_W-1:0] calc_base(input logic [CLR_W-1:0] color,
                                                   input logic [ORI_W-1:0] orient);
        return MEM_W'((int'(color) * N_ORIENT + int'(orient)) * SPR_W * SPR_H);
    endfunction

    function automatic logic [ADDR_W-1:0] calc_scr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return ADDR_W'(int'(y) * SCREEN_W + int'(x));
    endfunction

endpackage

// File: rtl/sprite_addr_scan_if.sv
// rtl/sprite_addr_scan_if.sv - request and beat handshake bundle for the sprite scanner
interface sprite_addr_scan_if
    import sprite_addr_scan_pkg::*;
();
    logic              req_valid;
    logic              req_ready;
    logic [X_W-1:0]    start_x;
    logic [Y_W-1:0]    start_y;
    logic [ORI_W-1:0]  orient;
    logic [CLR_W-1:0]  color;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] scr_addr;
    logic [MEM_W-1:0]  mem_addr;
    logic              done;

    modport master (
        output req_valid, start_x, start_y, orient, color, abort, out_ready,
        input  req_ready, out_valid, scr_addr, mem_addr, done
    );

    modport slave (
        input  req_valid, start_x, start_y, orient, color, abort, out_ready,
        output req_ready, out_valid, scr_addr, mem_addr, done
    );
endinterface

// File: rtl/sprite_addr_scan_clip_chk.sv
// rtl/sprite_addr_scan_clip_chk.sv - combinational screen-bounds test for one sprite pixel
module sprite_addr_scan_clip_chk
    import sprite_addr_scan_pkg::*;
(
    input  logic [X_W-1:0]   start_x_i,
    input  logic [Y_W-1:0]   start_y_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             in_bounds_o
);
    localparam int XS_W = X_W + 1;
    localparam int YS_W = Y_W + 1;
    localparam logic [XS_W-1:0] X_LIM = XS_W'(SCREEN_W);
    localparam logic [YS_W-1:0] Y_LIM = YS_W'(SCREEN_H);

    // One extra bit so start + offset never wraps back on-screen.
    logic [XS_W-1:0] x_sum;
    logic [YS_W-1:0] y_sum;

    assign x_sum       = {1'b0, start_x_i} + XS_W'(col_i);
    assign y_sum       = {1'b0, start_y_i} + YS_W'(row_i);
    assign in_bounds_o = (x_sum < X_LIM) && (y_sum < Y_LIM);
endmodule

// File: rtl/sprite_addr_scan.sv
// rtl/sprite_addr_scan.sv - rasters one sprite window into (screen, sprite-ROM) address beats
module sprite_addr_scan
    import sprite_addr_scan_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    sprite_addr_scan_if.slave  bus
);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SPR_H - 1);
    localparam logic [ADDR_W-1:0] SCR_WRAP = ADDR_W'(SCREEN_W - SPR_W + 1);

    state_e            state_q, state_d;
    logic [X_W-1:0]    sx_q, sx_d;
    logic [Y_W-1:0]    sy_q, sy_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] scr_q, scr_d;
    logic [MEM_W-1:0]  mem_q, mem_d;
    logic              out_valid_q;
    logic              done_q;
    logic              req_ready_q;
    logic              in_bounds_d;

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        col_d   = col_q;
        row_d   = row_q;
        scr_d   = scr_q;
        mem_d   = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_RUN;
                    sx_d    = bus.start_x;
                    sy_d    = bus.start_y;
                    col_d   = '0;
                    row_d   = '0;
                    mem_d   = calc_base(bus.color, bus.orient);
                    scr_d   = calc_scr(bus.start_x, bus.start_y);
                end
            end
            ST_RUN: begin
                // Clipped positions never wait for downstream.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!out_valid_q || bus.out_ready) begin
                    if (col_q == COL_LAST && row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        mem_d = mem_q + MEM_W'(1);
                        if (col_q != COL_LAST) begin
                            col_d = col_q + COL_W'(1);
                            scr_d = scr_q + ADDR_W'(1);
                        end else begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                            scr_d = scr_q + SCR_WRAP;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bounds are evaluated on the next position so out_valid can be registered.
    sprite_addr_scan_clip_chk u_clip (
        .start_x_i   (sx_d),
        .start_y_i   (sy_d),
        .col_i       (col_d),
        .row_i       (row_d),
        .in_bounds_o (in_bounds_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            scr_q       <= '0;
            mem_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            col_q       <= col_d;
            row_q       <= row_d;
            scr_q       <= scr_d;
            mem_q       <= mem_d;
            out_valid_q <= (state_d == ST_RUN) && in_bounds_d;
            done_q      <= (state_d == ST_DONE);
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.scr_addr  = scr_q;
    assign bus.mem_addr  = mem_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sprite_addr_scan.sv
// tb/tb_sprite_addr_scan.sv - randomized self-checking bench for sprite_addr_scan
module tb_sprite_addr_scan;
    import sprite_addr_scan_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sprite_addr_scan_if bus ();

    sprite_addr_scan dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected pixel sequence comes from (pos / SPR_W, pos % SPR_W) with plain arithmetic.
    task automatic run_scan(input int sx, input int sy, input int ori, input int clr,
                            input bit rand_rdy, input bit hold_req,
                            input int abort_at, input int reset_at,
                            output int nbeats, output int first_scr, output int first_mem,
                            output int last_scr, output int last_mem, output int done_cyc);
        int pos, cyc, c, r, base, escr, emem;
        bit inb, stopped;
        nbeats = 0; first_scr = -1; first_mem = -1; last_scr = -1; last_mem = -1;
        done_cyc = -1; pos = 0; cyc = 0; stopped = 0;
        base = (clr * N_ORIENT + ori) * SPR_W * SPR_H;
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.start_x   = X_W'(sx);
        bus.start_y   = Y_W'(sy);
        bus.orient    = ORI_W'(ori);
        bus.color     = CLR_W'(clr);
        bus.out_ready = 1'b1;
        while (pos < SPR_W * SPR_H && !stopped) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                chk("timeout", 0, 1);
                stopped = 1;
            end else begin
                if (hold_req) begin
                    bus.start_x = X_W'($urandom);
                    bus.start_y = Y_W'($urandom);
                    bus.orient  = ORI_W'($urandom);
                    bus.color   = CLR_W'($urandom);
                end else begin
                    bus.req_valid = 1'b0;
                end
                c    = pos % SPR_W;
                r    = pos / SPR_W;
                inb  = (sx + c < SCREEN_W) && (sy + r < SCREEN_H);
                escr = (sy + r) * SCREEN_W + sx + c;
                emem = base + pos;
                chk("req_ready_busy", bus.req_ready, 0);
                chk("out_valid", bus.out_valid, inb);
                chk("done_early", bus.done, 0);
                if (inb) begin
                    chk("scr_addr", bus.scr_addr, escr);
                    chk("mem_addr", bus.mem_addr, emem);
                end
                if (inb && nbeats == abort_at) begin
                    bus.req_valid = 1'b0;
                    bus.out_ready = 1'b0;
                    bus.abort     = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                    chk("abort_valid", bus.out_valid, 0);
                    chk("abort_ready", bus.req_ready, 1);
                    chk("abort_done", bus.done, 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_no_done", bus.done, 0);
                        chk("abort_idle_valid", bus.out_valid, 0);
                    end
                    stopped = 1;
                end else if (inb && nbeats == reset_at) begin
                    bus.req_valid = 1'b0;
                    bus.out_ready = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_valid", bus.out_valid, 0);
                    chk("rst_ready", bus.req_ready, 1);
                    chk("rst_done", bus.done, 0);
                    chk("rst_scr", bus.scr_addr, 0);
                    chk("rst_mem", bus.mem_addr, 0);
                    stopped = 1;
                end else if (inb) begin
                    bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (bus.out_ready) begin
                        if (nbeats == 0) begin
                            first_scr = escr;
                            first_mem = emem;
                        end
                        last_scr = escr;
                        last_mem = emem;
                        nbeats++;
                        pos++;
                    end
                end else begin
                    bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                    pos++;
                end
            end
        end
        if (!stopped) begin
            @(negedge clk);
            cyc++;
            done_cyc = cyc;
            chk("done_pulse", bus.done, 1);
            chk("done_valid", bus.out_valid, 0);
            chk("done_ready", bus.req_ready, 0);
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk("done_clear", bus.done, 0);
            chk("back_idle", bus.req_ready, 1);
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int nb, fs, fm, ls, lm, dc, sx, sy, ex, ey;
        bus.req_valid = 1'b0;
        bus.start_x   = '0;
        bus.start_y   = '0;
        bus.orient    = '0;
        bus.color     = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_scr_addr", bus.scr_addr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;

        run_scan(0, 0, 0, 0, 0, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t1_beats", nb, 900);
        chk("t1_first_scr", fs, 0);
        chk("t1_first_mem", fm, 0);
        chk("t1_last_scr", ls, 18589);
        chk("t1_last_mem", lm, 899);
        chk("t1_done_cyc", dc, 901);

        run_scan(10, 5, 1, 2, 0, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t2_beats", nb, 900);
        chk("t2_first_scr", fs, 3210);
        chk("t2_first_mem", fm, 8100);
        chk("t2_last_mem", lm, 8999);

        run_scan(620, 0, 0, 0, 0, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t3_beats", nb, 600);
        chk("t3_done_cyc", dc, 901);

        run_scan(0, 0, 0, 0, 1, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t4_beats", nb, 900);
        chk("t4_last_scr", ls, 18589);
        chk("t4_last_mem", lm, 899);

        run_scan(100, 100, 2, 1, 0, 0, 100, -1, nb, fs, fm, ls, lm, dc);
        chk("t5_abort_beats", nb, 100);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5_idle_abort_ready", bus.req_ready, 1);
        run_scan(50, 60, 3, 0, 1, 0, -1, 200, nb, fs, fm, ls, lm, dc);
        chk("t5_reset_beats", nb, 200);
        run_scan(300, 200, 3, 3, 0, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t5_after_beats", nb, 900);
        chk("t5_after_mem", fm, 13500);

        run_scan(40, 40, 2, 1, 0, 1, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t6_hold_beats", nb, 900);
        chk("t6_hold_mem", fm, 5400);
        run_scan(700, 0, 0, 0, 0, 0, -1, -1, nb, fs, fm, ls, lm, dc);
        chk("t6_off_beats", nb, 0);
        chk("t6_off_done_cyc", dc, 901);

        for (int k = 0; k < 6; k++) begin
            sx = (k % 2 == 0) ? $urandom_range(600, 700) : $urandom_range(0, 1023);
            sy = (k % 3 == 0) ? $urandom_range(440, 511) : $urandom_range(0, 511);
            ex = (SCREEN_W - sx > SPR_W) ? SPR_W : ((SCREEN_W > sx) ? SCREEN_W - sx : 0);
            ey = (SCREEN_H - sy > SPR_H) ? SPR_H : ((SCREEN_H > sy) ? SCREEN_H - sy : 0);
            run_scan(sx, sy, $urandom_range(0, 3), $urandom_range(0, 3), 1, 0, -1, -1,
                     nb, fs, fm, ls, lm, dc);
            chk("rand_beats", nb, ex * ey);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
